// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the alignment rule for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words a 4-byte boundary; bytes are always fine.
  // Unknown encodings behave like a word access, so they follow the word rule.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: is_aligned = 1'b1;
      F3_H, F3_HU: is_aligned = ~addr_lo[0];
      default:     is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic: byte enables and lane-replicated store data on
// the way out, lane extraction plus sign/zero extension on the way back in.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr_lo,
  input  logic [DATAWIDTH-1:0] i_store_data,
  input  logic [DATAWIDTH-1:0] i_load_data,
  output logic [3:0]           o_be,
  output logic [DATAWIDTH-1:0] o_wdata,
  output logic [DATAWIDTH-1:0] o_load_ext
);

  logic [7:0]  w_st_byte;
  logic [15:0] w_st_half;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  assign w_st_byte = i_store_data[7:0];
  assign w_st_half = i_store_data[15:0];
  assign w_ld_half = i_addr_lo[1] ? i_load_data[31:16] : i_load_data[15:0];

  // Store path: enable only the addressed lanes, copy the datum into every lane
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {(DATAWIDTH/8){w_st_byte}};
      end
      F3_H, F3_HU: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {(DATAWIDTH/16){w_st_half}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte lane of the returned word
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_ld_byte = i_load_data[7:0];
      2'd1:    w_ld_byte = i_load_data[15:8];
      2'd2:    w_ld_byte = i_load_data[23:16];
      default: w_ld_byte = i_load_data[31:24];
    endcase
  end

  // Load path: extend the selected lane to full width
  always_comb begin
    case (i_funct3)
      F3_B:    o_load_ext = {{(DATAWIDTH-8){w_ld_byte[7]}}, w_ld_byte};
      F3_BU:   o_load_ext = {{(DATAWIDTH-8){1'b0}}, w_ld_byte};
      F3_H:    o_load_ext = {{(DATAWIDTH-16){w_ld_half[15]}}, w_ld_half};
      F3_HU:   o_load_ext = {{(DATAWIDTH-16){1'b0}}, w_ld_half};
      default: o_load_ext = i_load_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/gnt/rvalid data-memory access at a time, stalls the
// core while it is open and returns the write-back value for the register file.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [2:0]           i_funct3,
  input  logic [DATAWIDTH-1:0] i_alu_out,
  input  logic [DATAWIDTH-1:0] i_reg_op2,
  output logic [DATAWIDTH-1:0] o_write_data,
  output logic                 o_stall,
  output logic                 o_misalign,
  output logic                 o_bus_req,
  output logic                 o_bus_we,
  output logic [ADDRWIDTH-1:0] o_bus_addr,
  output logic [3:0]           o_bus_be,
  output logic [DATAWIDTH-1:0] o_bus_wdata,
  input  logic                 i_bus_gnt,
  input  logic                 i_bus_rvalid,
  input  logic [DATAWIDTH-1:0] i_bus_rdata
);

  lsu_state_t r_state;
  lsu_state_t w_state_next;

  logic [ADDRWIDTH-1:0] r_addr;
  logic [1:0]           r_addr_lo;
  logic [3:0]           r_be;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [DATAWIDTH-1:0] r_load_data;
  logic                 r_we;
  logic [2:0]           r_funct3;

  logic                 w_mem_op;
  logic                 w_aligned;
  logic                 w_start;
  logic [2:0]           w_align_f3;
  logic [1:0]           w_align_lo;
  logic [3:0]           w_be;
  logic [DATAWIDTH-1:0] w_wdata;
  logic [DATAWIDTH-1:0] w_load_ext;

  // A held reset masks the instruction so stall drops immediately
  assign w_mem_op  = rst_n & (i_mem_read | i_mem_write);
  assign w_aligned = is_aligned(i_funct3, i_alu_out[1:0]);
  assign w_start   = (r_state == IDLE) & w_mem_op & w_aligned;

  // In IDLE the aligner shapes the incoming store; later it decodes the latched load
  assign w_align_f3 = (r_state == IDLE) ? i_funct3 : r_funct3;
  assign w_align_lo = (r_state == IDLE) ? i_alu_out[1:0] : r_addr_lo;

  lsu_align #(.DATAWIDTH(DATAWIDTH)) u_align (
    .i_funct3     (w_align_f3),
    .i_addr_lo    (w_align_lo),
    .i_store_data (i_reg_op2),
    .i_load_data  (i_bus_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_ext   (w_load_ext)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Latch the request when an access starts; capture load data when it returns.
  // When both MemRead and MemWrite are set the access is treated as a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_addr_lo   <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_load_data <= '0;
    end else begin
      if (w_start) begin
        r_addr    <= {i_alu_out[ADDRWIDTH-1:2], 2'b00};
        r_addr_lo <= i_alu_out[1:0];
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_we      <= i_mem_write;
        r_funct3  <= i_funct3;
      end
      if ((r_state == RSP) && i_bus_rvalid) r_load_data <= w_load_ext;
    end
  end

  // Next state, handshake outputs, stall and the write-back mux
  always_comb begin
    w_state_next = r_state;
    o_stall      = 1'b0;
    o_misalign   = 1'b0;
    o_bus_req    = 1'b0;
    o_write_data = i_alu_out;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_aligned) begin
            w_state_next = REQ;
            o_stall      = 1'b1;
          end else begin
            o_misalign   = 1'b1;
            o_write_data = '0;
          end
        end
      end
      REQ: begin
        o_bus_req = 1'b1;
        o_stall   = 1'b1;
        if (i_bus_gnt) w_state_next = r_we ? DONE : RSP;
      end
      RSP: begin
        o_stall = 1'b1;
        if (i_bus_rvalid) w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
        if (!r_we) o_write_data = r_load_data;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_bus_we    = r_we;
  assign o_bus_addr  = r_addr;
  assign o_bus_be    = r_be;
  assign o_bus_wdata = r_wdata;

  // A load and a store in the same instruction cannot come from a legal decoder
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_mem_read && i_mem_write));

endmodule
